// File: rtl/sad_search_engine_if.sv
// Row-beat stream into the SAD engine: one current-block row and one candidate row per beat,
// transferred on a clock edge where i_valid and o_ready are both high.
interface sad_search_engine_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 16
);
  logic               i_valid;
  logic               o_ready;
  logic [BLK*PIX_W-1:0] i_cur_row;
  logic [BLK*PIX_W-1:0] i_ref_row;

  modport master (output i_valid, output i_cur_row, output i_ref_row, input o_ready);
  modport slave  (input i_valid, input i_cur_row, input i_ref_row, output o_ready);
endinterface

// File: rtl/sad_search_engine.sv
// Block-matching SAD engine: |cur-ref| -> row adder tree -> accumulator pipeline,
// one SAD per candidate block, with a running minimum-SAD tracker over a search.
//
// state  | meaning
// IDLE   | waiting for i_start; row beats ignored
// ACCUM  | accepting row beats, counting rows and candidates
// DRAIN  | last beat taken, waiting for the final SAD to leave the pipeline
// DONE   | one-cycle o_done, best outputs final
module sad_search_engine #(
  parameter  int PIX_W  = 8,
  parameter  int BLK    = 16,
  parameter  int CAND_W = 8,
  localparam int LOG_B  = $clog2(BLK),
  localparam int SUM_W  = PIX_W + LOG_B,
  localparam int ACC_W  = PIX_W + 2*LOG_B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [CAND_W-1:0]  i_num_cand,
  sad_search_engine_if.slave i_row,
  output logic               o_sad_valid,
  output logic [ACC_W-1:0]   o_sad,
  output logic [CAND_W-1:0]  o_sad_idx,
  output logic               o_done,
  output logic [ACC_W-1:0]   o_best_sad,
  output logic [CAND_W-1:0]  o_best_idx,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam logic [LOG_B-1:0] ROW_LAST = LOG_B'(BLK-1);

  state_t              r_state, w_state_nxt;
  logic [LOG_B-1:0]    r_row;
  logic [CAND_W-1:0]   r_cand;
  logic [CAND_W-1:0]   r_last_idx;

  logic                w_accept;
  logic                w_row_last;
  logic                w_cand_last;
  logic                w_start_ok;

  logic                r_s1_valid, r_s1_first, r_s1_last;
  logic [CAND_W-1:0]   r_s1_cand;
  logic [BLK*PIX_W-1:0] r_s1_diff;
  logic [BLK*PIX_W-1:0] w_diff;

  logic                r_s2_valid, r_s2_first, r_s2_last;
  logic [CAND_W-1:0]   r_s2_cand;
  logic [SUM_W-1:0]    r_s2_sum;
  logic [SUM_W-1:0]    w_row_sum;

  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_nxt;

  assign w_start_ok  = (r_state == S_IDLE) && i_start;
  assign w_accept    = (r_state == S_ACCUM) && i_row.i_valid;
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_cand_last = (r_cand == r_last_idx);

  assign i_row.o_ready = (r_state == S_ACCUM);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DRAIN ends on the SAD of the final candidate, not on any earlier candidate still in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_accept && w_row_last && w_cand_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (o_sad_valid && (o_sad_idx == r_last_idx)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_cand     <= '0;
      r_last_idx <= '0;
    end else if (w_start_ok) begin
      r_row      <= '0;
      r_cand     <= '0;
      r_last_idx <= (i_num_cand == '0) ? '0 : i_num_cand - CAND_W'(1);
    end else if (w_accept) begin
      if (w_row_last) begin
        r_row <= '0;
        if (!w_cand_last) r_cand <= r_cand + CAND_W'(1);
      end else begin
        r_row <= r_row + LOG_B'(1);
      end
    end
  end

  always_comb begin
    w_diff = '0;
    for (int k = 0; k < BLK; k++) begin
      if (i_row.i_cur_row[PIX_W*k +: PIX_W] >= i_row.i_ref_row[PIX_W*k +: PIX_W])
        w_diff[PIX_W*k +: PIX_W] = i_row.i_cur_row[PIX_W*k +: PIX_W] - i_row.i_ref_row[PIX_W*k +: PIX_W];
      else
        w_diff[PIX_W*k +: PIX_W] = i_row.i_ref_row[PIX_W*k +: PIX_W] - i_row.i_cur_row[PIX_W*k +: PIX_W];
    end
  end

  always_comb begin
    w_row_sum = '0;
    for (int k = 0; k < BLK; k++)
      w_row_sum = w_row_sum + SUM_W'(r_s1_diff[PIX_W*k +: PIX_W]);
  end

  assign w_acc_nxt = r_s2_first ? ACC_W'(r_s2_sum) : r_acc + ACC_W'(r_s2_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cand  <= '0;
      r_s1_diff  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_cand  <= '0;
      r_s2_sum   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= (r_row == '0);
        r_s1_last  <= w_row_last;
        r_s1_cand  <= r_cand;
        r_s1_diff  <= w_diff;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_cand  <= r_s1_cand;
        r_s2_sum   <= w_row_sum;
      end
    end
  end

  // Strict less-than keeps the lowest index on ties; candidate 0 seeds the tracker unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      o_sad_valid <= 1'b0;
      o_sad       <= '0;
      o_sad_idx   <= '0;
      o_best_sad  <= '1;
      o_best_idx  <= '0;
    end else begin
      o_sad_valid <= r_s2_valid && r_s2_last;
      if (w_start_ok) begin
        o_best_sad <= '1;
        o_best_idx <= '0;
      end else if (r_s2_valid && r_s2_last) begin
        if ((r_s2_cand == '0) || (w_acc_nxt < o_best_sad)) begin
          o_best_sad <= w_acc_nxt;
          o_best_idx <= r_s2_cand;
        end
      end
      if (r_s2_valid) r_acc <= w_acc_nxt;
      if (r_s2_valid && r_s2_last) begin
        o_sad     <= w_acc_nxt;
        o_sad_idx <= r_s2_cand;
      end
    end
  end

endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench for sad_search_engine: expected SADs are queued as candidates are driven
// and popped when o_sad_valid fires; o_done checks best result and latency.
module tb_sad_search_engine;

  logic clk;
  logic rst_n;

  logic        i_start;
  logic [7:0]  i_num_cand;
  logic        o_sad_valid;
  logic [15:0] o_sad;
  logic [7:0]  o_sad_idx;
  logic        o_done;
  logic [15:0] o_best_sad;
  logic [7:0]  o_best_idx;
  logic        o_busy;

  logic        b_start;
  logic [7:0]  b_num_cand;
  logic        b_sad_valid;
  logic [13:0] b_sad;
  logic [7:0]  b_sad_idx;
  logic        b_done;
  logic [13:0] b_best_sad;
  logic [7:0]  b_best_idx;
  logic        b_busy;

  sad_search_engine_if #(.PIX_W(8),  .BLK(16)) row_if ();
  sad_search_engine_if #(.PIX_W(10), .BLK(4))  brow_if ();

  sad_search_engine #(.PIX_W(8), .BLK(16), .CAND_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_cand(i_num_cand), .i_row(row_if),
    .o_sad_valid(o_sad_valid), .o_sad(o_sad), .o_sad_idx(o_sad_idx), .o_done(o_done),
    .o_best_sad(o_best_sad), .o_best_idx(o_best_idx), .o_busy(o_busy)
  );

  sad_search_engine #(.PIX_W(10), .BLK(4), .CAND_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_num_cand(b_num_cand), .i_row(brow_if),
    .o_sad_valid(b_sad_valid), .o_sad(b_sad), .o_sad_idx(b_sad_idx), .o_done(b_done),
    .o_best_sad(b_best_sad), .o_best_idx(b_best_idx), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int sad; int idx; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int exp_best_sad = 0;
  int exp_best_idx = 0;
  int poke_row = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (row_if.i_valid && row_if.o_ready) begin
      acc_cnt++;
      last_acc = cyc + 1;
    end
    if (o_sad_valid) begin
      if (sb_q.size() == 0) begin
        check("sad_unexpected", o_sad_valid, 0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sad", o_sad, sb_e.sad);
        check("sad_idx", o_sad_idx, sb_e.idx);
      end
    end
    if (o_done) begin
      done_cnt++;
      check("best_sad", o_best_sad, exp_best_sad);
      check("best_idx", o_best_idx, exp_best_idx);
      check("done_latency", cyc - last_acc, 3);
      check("sb_empty_at_done", sb_q.size(), 0);
    end
  end

  task automatic start_search(input int n);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_cand = n[7:0];
    @(posedge clk); #1;
    i_start = 1'b0;
    i_num_cand = 8'd7;
    check("busy_rise", o_busy, 1);
    check("ready_rise", row_if.o_ready, 1);
  endtask

  task automatic send_beat(input logic [127:0] c, input logic [127:0] r, input bit gaps);
    logic rdy;
    int guard;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        row_if.i_valid = 1'b0;
        row_if.i_cur_row = {4{$urandom}};
        row_if.i_ref_row = {4{$urandom}};
        @(posedge clk); #1;
      end
    end
    row_if.i_valid = 1'b1;
    row_if.i_cur_row = c;
    row_if.i_ref_row = r;
    forever begin
      @(negedge clk);
      rdy = row_if.o_ready;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        check("beat_timeout", rdy, 1);
        break;
      end
    end
    row_if.i_valid = 1'b0;
  endtask

  // Uniform fills bc/br; 'extra' is spread over leading pixels as +/- deviations of the ref (bc==br).
  task automatic send_cand(input int idx, input int bc, input int br, input int extra,
                           input int exp_sad, input int rows, input bit gaps);
    logic [127:0] c_row, r_row;
    int rem, d, f;
    exp_t e;
    rem = extra;
    if (rows == 16) begin
      e.sad = exp_sad;
      e.idx = idx;
      sb_q.push_back(e);
    end
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < 16; k++) begin
        f = br;
        if (rem > 0) begin
          d = (rem > 100) ? 100 : rem;
          rem -= d;
          f = (k % 2 == 1) ? br + d : br - d;
        end
        c_row[8*k +: 8] = bc[7:0];
        r_row[8*k +: 8] = f[7:0];
      end
      if (r == poke_row) begin
        i_start = 1'b1;
        i_num_cand = 8'd1;
      end
      send_beat(c_row, r_row, gaps);
      i_start = 1'b0;
    end
  endtask

  task automatic wait_done(input bit hold_valid);
    int base, guard;
    base = done_cnt;
    guard = 0;
    if (hold_valid) begin
      row_if.i_valid = 1'b1;
      row_if.i_cur_row = {4{$urandom}};
      row_if.i_ref_row = {4{$urandom}};
    end
    while (done_cnt == base && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", done_cnt, base + 1);
    row_if.i_valid = 1'b0;
    check("busy_fall", o_busy, 0);
    check("ready_idle", row_if.o_ready, 0);
  endtask

  task automatic run_four(input bit gaps, input bit hold);
    start_search(4);
    exp_best_sad = 120;
    exp_best_idx = 1;
    send_cand(0, 128, 128, 300, 300, 16, gaps);
    send_cand(1, 128, 128, 120, 120, 16, gaps);
    send_cand(2, 128, 128, 120, 120, 16, gaps);
    send_cand(3, 128, 128, 500, 500, 16, gaps);
    wait_done(hold);
  endtask

  initial begin
    int base, guard;
    rst_n = 1'b1;
    i_start = 1'b0;
    i_num_cand = 8'd0;
    row_if.i_valid = 1'b0;
    row_if.i_cur_row = '0;
    row_if.i_ref_row = '0;
    b_start = 1'b0;
    b_num_cand = 8'd0;
    brow_if.i_valid = 1'b0;
    brow_if.i_cur_row = '0;
    brow_if.i_ref_row = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", row_if.o_ready, 0);
    check("rst_sad_valid", o_sad_valid, 0);
    check("rst_sad", o_sad, 0);
    check("rst_sad_idx", o_sad_idx, 0);
    check("rst_done", o_done, 0);
    check("rst_best_sad", o_best_sad, 16'hFFFF);
    check("rst_best_idx", o_best_idx, 0);
    check("rst_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // single candidate, identical rows
    start_search(1);
    exp_best_sad = 0;
    exp_best_idx = 0;
    send_cand(0, 16, 16, 0, 0, 16, 1'b0);
    wait_done(1'b0);

    // saturation both ways
    start_search(1);
    exp_best_sad = 65280;
    send_cand(0, 255, 0, 0, 65280, 16, 1'b0);
    wait_done(1'b0);
    start_search(1);
    send_cand(0, 0, 255, 0, 65280, 16, 1'b0);
    wait_done(1'b0);

    // four candidates with a tie
    run_four(1'b0, 1'b0);

    // same with random valid gaps and valid held through DRAIN/DONE
    acc_cnt = 0;
    run_four(1'b1, 1'b1);
    check("beat_count", acc_cnt, 64);

    // abort during row 7 of candidate 2
    start_search(4);
    exp_best_sad = 120;
    exp_best_idx = 1;
    send_cand(0, 128, 128, 300, 300, 16, 1'b0);
    send_cand(1, 128, 128, 120, 120, 16, 1'b0);
    send_cand(2, 128, 128, 0, 0, 7, 1'b0);
    row_if.i_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", row_if.o_ready, 0);
    check("abort_busy", o_busy, 0);
    check("abort_sad_valid", o_sad_valid, 0);
    check("abort_sad", o_sad, 0);
    check("abort_sad_idx", o_sad_idx, 0);
    check("abort_best_sad", o_best_sad, 16'hFFFF);
    check("abort_best_idx", o_best_idx, 0);
    check("abort_sb_empty", sb_q.size(), 0);
    row_if.i_valid = 1'b0;
    base = done_cnt;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, base);
    start_search(1);
    exp_best_sad = 40;
    exp_best_idx = 0;
    send_cand(0, 128, 128, 40, 40, 16, 1'b0);
    wait_done(1'b0);

    // i_start pulsed mid-search is ignored
    poke_row = 5;
    run_four(1'b0, 1'b0);
    poke_row = -1;

    // num_cand = 0 behaves as one candidate
    start_search(0);
    exp_best_sad = 77;
    exp_best_idx = 0;
    send_cand(0, 128, 128, 77, 77, 16, 1'b0);
    wait_done(1'b0);

    // BLK=4, PIX_W=10 instance
    @(posedge clk); #1;
    b_start = 1'b1;
    b_num_cand = 8'd1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_ready", brow_if.o_ready, 1);
    for (int r = 0; r < 4; r++) begin
      brow_if.i_valid = 1'b1;
      brow_if.i_cur_row = {4{10'h3FF}};
      brow_if.i_ref_row = '0;
      @(posedge clk); #1;
    end
    brow_if.i_valid = 1'b0;
    guard = 0;
    while (!b_sad_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("b_sad_valid_seen", b_sad_valid, 1);
    check("b_sad", b_sad, 16368);
    check("b_sad_idx", b_sad_idx, 0);
    guard = 0;
    while (!b_done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("b_done_seen", b_done, 1);
    check("b_best_sad", b_best_sad, 16368);
    check("b_best_idx", b_best_idx, 0);
    @(posedge clk); #1;
    check("b_busy_fall", b_busy, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
